// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - state encoding and field limits shared by the alarm-set logic
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_W   = 5;
    localparam int MIN_W    = 6;

endpackage

// File: rtl/alarm_set_fsm_wrap_counter.sv
// rtl/alarm_set_fsm_wrap_counter.sv - loadable mod-(MAX+1) up/down counter for one shadow field
module wrap_counter #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    // load has priority; inc and dec together cancel out
    always_ff @(posedge clk) begin
        if (load) begin
            count <= load_value;
        end else if (inc && !dec) begin
            count <= (count == W'(MAX)) ? '0 : count + W'(1);
        end else if (dec && !inc) begin
            count <= (count == '0) ? W'(MAX) : count - W'(1);
        end
    end

endmodule

// File: rtl/alarm_set_fsm.sv
// rtl/alarm_set_fsm.sv - button-driven alarm time editor with shadow registers and timeout
// Optional blink mask generation is enabled by defining BLINK_EN.
module alarm_set_fsm
    import alarm_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 10,
    parameter int RESET_HOUR    = 7,
    parameter int RESET_MIN     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic              mode_pulse,
    input  logic              up_pulse,
    input  logic              down_pulse,
    input  logic              arm_pulse,
    output logic [HOUR_W-1:0] alarm_hour,
    output logic [MIN_W-1:0]  alarm_min,
    output logic [HOUR_W-1:0] edit_hour,
    output logic [MIN_W-1:0]  edit_min,
    output logic              editing,
    output logic              edit_field,
    output logic              alarm_armed,
    output logic              commit,
    output logic              blank_hour,
    output logic              blank_min
);

    localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  idle_cnt, idle_cnt_next;
    logic              armed_next;
    logic              commit_next;
    logic              shadow_load;
    logic              hour_inc, hour_dec, min_inc, min_dec;
    logic              any_btn;

    assign any_btn = mode_pulse | up_pulse | down_pulse | arm_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idle_cnt    <= '0;
            alarm_hour  <= HOUR_W'(RESET_HOUR);
            alarm_min   <= MIN_W'(RESET_MIN);
            alarm_armed <= 1'b0;
            commit      <= 1'b0;
        end else begin
            state       <= state_next;
            idle_cnt    <= idle_cnt_next;
            alarm_armed <= armed_next;
            commit      <= commit_next;
            if (commit_next) begin
                alarm_hour <= edit_hour;
                alarm_min  <= edit_min;
            end
        end
    end

    always_comb begin
        state_next    = state;
        idle_cnt_next = idle_cnt;
        armed_next    = alarm_armed;
        commit_next   = 1'b0;
        shadow_load   = 1'b0;
        hour_inc      = 1'b0;
        hour_dec      = 1'b0;
        min_inc       = 1'b0;
        min_dec       = 1'b0;

        case (state)
            IDLE: begin
                idle_cnt_next = '0;
                if (arm_pulse) armed_next = ~alarm_armed;
                if (mode_pulse) begin
                    state_next  = SET_HOUR;
                    shadow_load = 1'b1;
                end
            end
            SET_HOUR: begin
                if (mode_pulse) begin
                    state_next = SET_MIN;
                end else begin
                    hour_inc = up_pulse;
                    hour_dec = down_pulse;
                end
            end
            SET_MIN: begin
                if (mode_pulse) begin
                    state_next  = IDLE;
                    commit_next = 1'b1;
                end else begin
                    min_inc = up_pulse;
                    min_dec = down_pulse;
                end
            end
            default: state_next = IDLE;
        endcase

        // a button on the expiring tick keeps the edit alive
        if (state == SET_HOUR || state == SET_MIN) begin
            if (any_btn) begin
                idle_cnt_next = '0;
            end else if (tick_1hz) begin
                if (idle_cnt == CNT_W'(TIMEOUT_TICKS - 1)) begin
                    idle_cnt_next = '0;
                    state_next    = IDLE;
                    shadow_load   = 1'b1;
                end else begin
                    idle_cnt_next = idle_cnt + CNT_W'(1);
                end
            end
        end
    end

    wrap_counter #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk        (clk),
        .load       (rst | shadow_load),
        .load_value (rst ? HOUR_W'(RESET_HOUR) : alarm_hour),
        .inc        (hour_inc),
        .dec        (hour_dec),
        .count      (edit_hour)
    );

    wrap_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk        (clk),
        .load       (rst | shadow_load),
        .load_value (rst ? MIN_W'(RESET_MIN) : alarm_min),
        .inc        (min_inc),
        .dec        (min_dec),
        .count      (edit_min)
    );

    assign editing    = (state == SET_HOUR) || (state == SET_MIN);
    assign edit_field = (state == SET_MIN);

`ifdef BLINK_EN
    logic phase;

    always_ff @(posedge clk) begin
        if (rst || state == IDLE || state_next == IDLE) begin
            phase <= 1'b0;
        end else if (up_pulse || down_pulse) begin
            phase <= 1'b0;
        end else if (tick_1hz) begin
            phase <= ~phase;
        end
    end

    assign blank_hour = phase && (state == SET_HOUR);
    assign blank_min  = phase && (state == SET_MIN);
`else
    assign blank_hour = 1'b0;
    assign blank_min  = 1'b0;
`endif

endmodule
